layer_activation_collector: RTL and testbench

- Sits directly downstream of the `layer` block.
- Captures each neuron's output when its per-neuron valid asserts, and waits until every active neuron of the current pass has reported.
- Then applies a saturating ReLU serially, one neuron per cycle, and rescales to the next layer's input format.
- Presents the whole vector with a valid/ready handshake to the multiplexed next-layer input.

---
 rtl/layer_activation_collector_if.sv | 14 +
 rtl/layer_activation_collector.sv | 125 ++++++++++++
 tb/tb_layer_activation_collector.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/layer_activation_collector_if.sv
// Output-side bus of the activation collector: the full activated vector
// plus its valid/ready handshake toward the next layer's input mux.
interface layer_activation_collector_if #(
    parameter int NUM_NEURON  = 6,
    parameter int OUTPUT_SIZE = 9
);
    logic [NUM_NEURON*OUTPUT_SIZE-1:0] out_values;
    logic                              out_valid;
    logic                              out_ready;

    // Collector drives the vector and valid; the consumer drives ready.
    modport master (output out_values, output out_valid, input out_ready);
    modport slave  (input out_values, input out_valid, output out_ready);
endinterface

// File: rtl/layer_activation_collector.sv
// Gathers one output per active neuron from the layer, then applies a
// saturating ReLU with fraction rescale one lane per cycle, and offers the
// finished vector to the next layer over a valid/ready handshake.
module layer_activation_collector #(
    parameter int NUM_NEURON      = 6,
    parameter int INPUT_SIZE      = 10,
    parameter int INPUT_FRACTION  = 7,
    parameter int OUTPUT_SIZE     = 9,
    parameter int OUTPUT_FRACTION = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_NEURON-1:0]            active,
    input  logic [NUM_NEURON*INPUT_SIZE-1:0] in_values,
    input  logic [NUM_NEURON-1:0]            in_valid,
    layer_activation_collector_if.master     out_if,
    output logic                             busy
);
    localparam int SHIFT = OUTPUT_FRACTION - INPUT_FRACTION;
    localparam int IDX_W = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
    // Wide enough to hold any non-negative input after the left shift.
    localparam int MAG_W = (INPUT_SIZE + SHIFT > OUTPUT_SIZE) ? (INPUT_SIZE + SHIFT) : OUTPUT_SIZE;
    localparam logic [MAG_W-1:0] SAT_MAX  = MAG_W'((64'd1 << (OUTPUT_SIZE - 1)) - 64'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURON - 1);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        ACTIVATE,
        OUTPUT
    } state_t;

    state_t                  state;
    logic [NUM_NEURON-1:0]   active_r;
    logic [NUM_NEURON-1:0]   captured;
    logic [INPUT_SIZE-1:0]   cap_values [NUM_NEURON];
    logic [OUTPUT_SIZE-1:0]  out_lanes  [NUM_NEURON];
    logic [IDX_W-1:0]        idx;
    logic                    out_valid_r;
    logic                    all_captured;
    logic [INPUT_SIZE-1:0]   lane_val;
    logic [MAG_W-1:0]        lane_mag;
    logic [OUTPUT_SIZE-1:0]  lane_act;

    // Collection is complete once every lane enabled for this pass is latched.
    assign all_captured = ((captured & active_r) == active_r);

    // Saturating ReLU and fraction rescale of the lane currently selected by idx.
    always_comb begin
        // NOTE: lane_act is given a default before any condition so every path assigns it and no latch is inferred.
        lane_act = '0;
        lane_val = cap_values[idx];
        lane_mag = MAG_W'(lane_val) << SHIFT;
        if (active_r[idx] && !lane_val[INPUT_SIZE-1]) begin
            lane_act = (lane_mag > SAT_MAX) ? SAT_MAX[OUTPUT_SIZE-1:0] : lane_mag[OUTPUT_SIZE-1:0];
        end
    end

    // Control FSM: collect lanes, activate serially, hold the vector until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
            state       <= IDLE;
            active_r    <= '0;
            captured    <= '0;
            idx         <= '0;
            out_valid_r <= 1'b0;
            // NOTE: the lane arrays are reset as well, so an aborted pass leaves no stale data visible.
            for (int i = 0; i < NUM_NEURON; i++) begin
                cap_values[i] <= '0;
                out_lanes[i]  <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        active_r <= active;
                        captured <= '0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    // First valid value per active lane wins; later changes are ignored.
                    for (int i = 0; i < NUM_NEURON; i++) begin
                        if (active_r[i] && in_valid[i] && !captured[i]) begin
                            cap_values[i] <= in_values[i*INPUT_SIZE +: INPUT_SIZE];
                            captured[i]   <= 1'b1;
                        end
                    end
                    if (all_captured) begin
                        idx   <= '0;
                        state <= ACTIVATE;
                    end
                end
                ACTIVATE: begin
                    out_lanes[idx] <= lane_act;
                    if (idx == LAST_IDX) begin
                        idx         <= '0;
                        out_valid_r <= 1'b1;
                        state       <= OUTPUT;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                OUTPUT: begin
                    // A start arriving on the accepting edge is dropped.
                    if (out_valid_r && out_if.out_ready) begin
                        out_valid_r <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy             = (state != IDLE);
    assign out_if.out_valid = out_valid_r;

    // Flatten the lane registers onto the output bus, lane i at the low end first.
    for (genvar g = 0; g < NUM_NEURON; g++) begin : g_lane
        assign out_if.out_values[g*OUTPUT_SIZE +: OUTPUT_SIZE] = out_lanes[g];
    end
endmodule

// File: tb/tb_layer_activation_collector.sv
// Self-checking bench for layer_activation_collector at default parameters:
// a vector table for the main ReLU/scale behaviour plus hand-written
// sequences for reset, staggered valids, backpressure and the empty mask.
module tb_layer_activation_collector;
    localparam int N  = 6;
    localparam int IS = 10;
    localparam int OS = 9;
    // Edges after the capture edge until out_valid is seen high
    // (N+2 edges when the capture edge itself is counted).
    localparam int LAT = N + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [N-1:0]      active = '0;
    logic [N-1:0]      in_valid = '0;
    logic [N*IS-1:0]   in_values = '0;
    logic              busy;

    layer_activation_collector_if #(.NUM_NEURON(N), .OUTPUT_SIZE(OS)) bus ();

    layer_activation_collector #(
        .NUM_NEURON(N), .INPUT_SIZE(IS), .INPUT_FRACTION(7),
        .OUTPUT_SIZE(OS), .OUTPUT_FRACTION(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .active(active),
        .in_values(in_values),
        .in_valid(in_valid),
        .out_if(bus.master),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [N*OS-1:0] exp_q [$];

    typedef struct packed {
        logic [N-1:0]    active;
        logic [N-1:0]    valid;
        logic [N*IS-1:0] vals;
        logic [N*OS-1:0] exp;
    } vec_t;

    vec_t tbl [4];

    function automatic logic [N*IS-1:0] pack_in(input int v0, input int v1, input int v2,
                                                input int v3, input int v4, input int v5);
        return {IS'(v5), IS'(v4), IS'(v3), IS'(v2), IS'(v1), IS'(v0)};
    endfunction

    function automatic logic [N*OS-1:0] pack_out(input int v0, input int v1, input int v2,
                                                 input int v3, input int v4, input int v5);
        return {OS'(v5), OS'(v4), OS'(v3), OS'(v2), OS'(v1), OS'(v0)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Pulse start for one edge; returns just after the start edge.
    task automatic pulse_start(input logic [N-1:0] mask);
        start  = 1'b1;
        active = mask;
        tick();
        start  = 1'b0;
    endtask

    // Bounded wait for out_valid; the edge count is itself a comparison.
    task automatic await_output(input string name, input int exp_lat);
        int n = 0;
        while (!bus.out_valid && n < 100) begin
            tick();
            n++;
        end
        check({name, " latency"}, 64'(n), 64'(exp_lat));
    endtask

    // Accept the vector: compare against the scoreboard, then confirm the handshake retired it.
    task automatic accept(input string name);
        bus.out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: output with empty scoreboard, got 0x%0h", name, bus.out_values);
        end else begin
            check({name, " values"}, 64'(bus.out_values), 64'(exp_q.pop_front()));
        end
        tick();
        bus.out_ready = 1'b0;
        check({name, " valid drop"}, 64'(bus.out_valid), 64'(0));
        check({name, " idle"}, 64'(busy), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    initial begin
        logic [N*OS-1:0] bp_exp;

        tbl[0] = '{active: 6'b111111, valid: 6'b111111,
                   vals: pack_in(100, -50, 300, 127, 128, -512), exp: pack_out(200, 0, 255, 254, 255, 0)};
        tbl[1] = '{active: 6'b000011, valid: 6'b000111,
                   vals: pack_in(64, -1, 100, 0, 0, 0),          exp: pack_out(128, 0, 0, 0, 0, 0)};
        tbl[2] = '{active: 6'b100000, valid: 6'b111111,
                   vals: pack_in(100, 100, 100, 100, 100, 511),  exp: pack_out(0, 0, 0, 0, 0, 255)};
        tbl[3] = '{active: 6'b101010, valid: 6'b101010,
                   vals: pack_in(5, 0, 1, 60, -1, 127),          exp: pack_out(0, 0, 0, 120, 0, 254)};

        bus.out_ready = 1'b0;
        rst = 1'b0;
        repeat (3) tick();
        check("reset out_valid", 64'(bus.out_valid), 64'(0));
        check("reset busy", 64'(busy), 64'(0));
        check("reset out_values", 64'(bus.out_values), 64'(0));
        rst = 1'b1;
        tick();

        // Table-driven passes: all requested lanes valid on the first COLLECT edge.
        for (int t = 0; t < 4; t++) begin
            in_values = tbl[t].vals;
            pulse_start(tbl[t].active);
            in_valid = tbl[t].valid;
            exp_q.push_back(tbl[t].exp);
            tick();
            check($sformatf("vec%0d busy", t), 64'(busy), 64'(1));
            in_valid = '0;
            await_output($sformatf("vec%0d", t), LAT);
            accept($sformatf("vec%0d", t));
        end

        // Reset in the middle of COLLECT discards the partial pass.
        in_values = pack_in(5, 0, 0, 0, 0, 0);
        pulse_start(6'b111111);
        in_valid = 6'b000001;
        tick();
        check("mid busy", 64'(busy), 64'(1));
        rst = 1'b0;
        #1;
        check("async busy", 64'(busy), 64'(0));
        check("async out_values", 64'(bus.out_values), 64'(0));
        repeat (5) tick();
        check("held busy", 64'(busy), 64'(0));
        check("held out_valid", 64'(bus.out_valid), 64'(0));
        rst = 1'b1;
        in_values = pack_in(10, 0, 0, 0, 0, 0);
        repeat (3) tick();
        check("no resume", 64'(busy), 64'(0));
        exp_q.push_back(pack_out(20, 0, 0, 0, 0, 0));
        pulse_start(6'b000001);
        tick();
        in_valid = '0;
        await_output("post-reset", LAT);
        accept("post-reset");

        // Staggered valids: lane0 at edge 3, lane1 at edge 10, lane1 value changes later.
        in_values = pack_in(50, 30, 0, 0, 0, 0);
        exp_q.push_back(pack_out(100, 60, 0, 0, 0, 0));
        pulse_start(6'b000011);
        repeat (2) tick();
        in_valid = 6'b000001;
        tick();
        in_values = pack_in(7, 30, 0, 0, 0, 0);
        repeat (6) tick();
        check("stagger waiting busy", 64'(busy), 64'(1));
        check("stagger waiting valid", 64'(bus.out_valid), 64'(0));
        in_valid = 6'b000011;
        tick();
        tick();
        in_values = pack_in(7, 99, 0, 0, 0, 0);
        await_output("stagger", LAT - 1);
        in_valid = '0;
        accept("stagger");

        // Backpressure: vector held for 20 cycles, a start in the window is ignored.
        in_values = pack_in(1, 2, 3, 4, 5, 6);
        bp_exp = pack_out(2, 4, 6, 8, 10, 12);
        exp_q.push_back(bp_exp);
        pulse_start(6'b111111);
        in_valid = 6'b111111;
        tick();
        in_valid = '0;
        await_output("backpressure", LAT);
        for (int c = 0; c < 20; c++) begin
            if (c == 10) begin
                start  = 1'b1;
                active = '0;
            end
            tick();
            start = 1'b0;
            check($sformatf("bp hold valid c%0d", c), 64'(bus.out_valid), 64'(1));
            check($sformatf("bp hold values c%0d", c), 64'(bus.out_values), 64'(bp_exp));
        end
        check("bp busy", 64'(busy), 64'(1));
        // Start coincides with the accepting edge: the handshake wins.
        start  = 1'b1;
        active = 6'b111111;
        accept("backpressure");
        start = 1'b0;
        tick();
        check("start dropped", 64'(busy), 64'(0));

        // Empty mask: no valids needed, all lanes zero.
        exp_q.push_back(pack_out(0, 0, 0, 0, 0, 0));
        pulse_start('0);
        await_output("empty", LAT);
        accept("empty");

        check("scoreboard drained", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
